mul_result: RTL and testbench

MUL_RESULT -- requirements
Module: mul_result

---
 rtl/mdu_pkg.sv | 17 +
 rtl/mdu_pipereg.sv | 15 +
 rtl/mul_result.sv | 74 +++++++
 tb/tb_mul_result.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared multiply/divide encodings and XLEN checks.
package mdu_pkg;
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mul_f3_e;

    function automatic bit xlen_legal(int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit xlen_has_w(int xlen);
        return xlen == 64;
    endfunction
endpackage

// File: rtl/mdu_pipereg.sv
// mdu_pipereg: enabled pipeline register with synchronous clear and active-low async reset.
module mdu_pipereg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge reset)
        if (!reset)  q <= '0;
        else if (en) q <= clear ? '0 : d;
endmodule

// File: rtl/mul_result.sv
// mul_result: multiply result select and E->M->W pipelining.
// Define MDU_MULW_EN (XLEN=64 only) to sign-extend the low word for *W multiplies.
module mul_result
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallM,
    input  logic              FlushM,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic              MulE,
    input  logic [2:0]        Funct3E,
    input  logic              W64E,
    input  logic [2*XLEN-1:0] ProdM,
    output logic [XLEN-1:0]   MulResultM,
    output logic              MulValidM,
    output logic [XLEN-1:0]   MulResultW,
    output logic              MulValidW
);
`ifdef MDU_MULW_EN
    localparam bit MULW = xlen_has_w(XLEN);
`else
    localparam bit MULW = 1'b0;
`endif
    localparam int MW = MULW ? 4 : 3;

    logic [MW-1:0]   em_d, em_q;
    logic [1:0]      funct3m;
    logic            w64m;
    logic [XLEN-1:0] lo, hi, wres;
    logic [XLEN:0]   mw_q;

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("mul_result: XLEN must be 32 or 64");
    end

    assign lo = ProdM[XLEN-1:0];
    assign hi = ProdM[2*XLEN-1:XLEN];

    if (MULW) begin : g_w64
        assign em_d = {MulE & ~Funct3E[2], Funct3E[1:0], W64E};
        assign w64m = em_q[0];
        assign wres = {{32{ProdM[31]}}, ProdM[31:0]};
    end else begin : g_no_w64
        logic unused_w64;
        assign unused_w64 = W64E;
        assign em_d = {MulE & ~Funct3E[2], Funct3E[1:0]};
        assign w64m = 1'b0;
        assign wres = lo;
    end

    mdu_pipereg #(.W(MW)) u_em (
        .clk(clk), .reset(reset), .en(~StallM), .clear(FlushM), .d(em_d), .q(em_q)
    );

    assign MulValidM = em_q[MW-1];
    assign funct3m   = em_q[MW-2:MW-3];

    always_comb
        MulResultM = !MulValidM ? '0 :
                     w64m ? wres :
                     ({1'b0, funct3m} == MUL) ? lo : hi;

    mdu_pipereg #(.W(XLEN+1)) u_mw (
        .clk(clk), .reset(reset), .en(~StallW), .clear(FlushW),
        .d({MulValidM, MulResultM}), .q(mw_q)
    );

    assign MulValidW  = mw_q[XLEN];
    assign MulResultW = mw_q[XLEN-1:0];
endmodule

// File: tb/tb_mul_result.sv
// tb_mul_result: directed scoreboard bench for mul_result at XLEN=64.
module tb_mul_result;
    logic         clk = 0, reset = 0;
    logic         StallM = 0, FlushM = 0, StallW = 0, FlushW = 0;
    logic         MulE = 0, W64E = 0;
    logic [2:0]   Funct3E = 0;
    logic [127:0] ProdM = 0;
    logic [63:0]  MulResultM, MulResultW;
    logic         MulValidM, MulValidW;
    int tests = 0, fails = 0;
    logic [64:0] sb[$];
    logic [64:0] exp_v;
`ifdef MDU_MULW_EN
    localparam bit MULW = 1'b1;
`else
    localparam bit MULW = 1'b0;
`endif

    mul_result #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM), .StallW(StallW),
        .FlushW(FlushW), .MulE(MulE), .Funct3E(Funct3E), .W64E(W64E), .ProdM(ProdM),
        .MulResultM(MulResultM), .MulValidM(MulValidM), .MulResultW(MulResultW),
        .MulValidW(MulValidW)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic mule, input logic [2:0] f3,
                                          input logic w64, input logic [127:0] p);
        if (!(mule && !f3[2])) return '0;
        if (w64 && MULW) return {1'b1, {32{p[31]}}, p[31:0]};
        return {1'b1, (f3[1:0] == 2'b00) ? p[63:0] : p[127:64]};
    endfunction

    localparam int N = 8;
    logic         op_e[N];
    logic [2:0]   op_f3[N];
    logic         op_w[N];
    logic [127:0] op_p[N];

    initial begin
        op_e  = '{1, 1, 1, 1, 1, 1, 0, 1};
        op_f3 = '{3'b000, 3'b011, 3'b000, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000};
        op_w  = '{0, 0, 1, 0, 0, 0, 0, 0};
        op_p[0] = {64'h1, 64'hFFFF_FFFF_FFFF_FFFE};
        op_p[1] = op_p[0];
        op_p[2] = {64'h0, 64'h0000_0000_8000_0000};
        for (int i = 3; i < N; i++) op_p[i] = {$urandom, $urandom, $urandom, $urandom};

        // reset state
        #3;
        chk("rst_validM", MulValidM, 0);
        chk("rst_resM", MulResultM, 0);
        chk("rst_validW", MulValidW, 0);
        chk("rst_resW", MulResultW, 0);
        @(negedge clk);
        reset = 1;

        // back-to-back ops through the scoreboard
        for (int i = 0; i <= N; i++) begin
            if (i < N) begin
                MulE = op_e[i]; Funct3E = op_f3[i]; W64E = op_w[i];
            end else MulE = 0;
            tick;
            if (i > 0) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 1);
                exp_v = sb.pop_front();
                chk($sformatf("op%0d_resW", i-1), MulResultW, exp_v[63:0]);
                chk($sformatf("op%0d_validW", i-1), MulValidW, exp_v[64]);
            end
            if (i < N) begin
                ProdM = op_p[i];
                #1;
                exp_v = model(op_e[i], op_f3[i], op_w[i], op_p[i]);
                chk($sformatf("op%0d_resM", i), MulResultM, exp_v[63:0]);
                chk($sformatf("op%0d_validM", i), MulValidM, exp_v[64]);
                sb.push_back(exp_v);
            end
        end

        // stall / duplicate / flush
        MulE = 1; Funct3E = 3'b000; W64E = 0;
        tick;
        ProdM = {64'hAAAA_0000_1111_2222, 64'h1234_5678_9ABC_DEF0};
        Funct3E = 3'b011;
        tick;
        ProdM = {64'h5555_6666_7777_8888, 64'h0BAD_F00D_0000_0001};
        chk("stg_resW", MulResultW, 64'h1234_5678_9ABC_DEF0);
        StallW = 1; StallM = 1; Funct3E = 3'b000;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("stallW%0d_resW", k), MulResultW, 64'h1234_5678_9ABC_DEF0);
            chk($sformatf("stallM%0d_resM", k), MulResultM, 64'h5555_6666_7777_8888);
        end
        StallW = 0;
        for (int k = 0; k < 2; k++) begin
            tick;
            chk($sformatf("dup%0d_resW", k), MulResultW, 64'h5555_6666_7777_8888);
            chk($sformatf("dup%0d_validW", k), MulValidW, 1);
        end
        FlushW = 1;
        tick;
        chk("flushW_validW", MulValidW, 0);
        chk("flushW_resW", MulResultW, 0);
        FlushW = 0; StallW = 1; FlushM = 1;
        tick;
        chk("flushM_stalled_validM", MulValidM, 1);
        StallM = 0;
        tick;
        chk("flushM_validM", MulValidM, 0);
        chk("flushM_resM", MulResultM, 0);
        FlushM = 0; StallW = 0;

        // asynchronous reset with ops in flight
        MulE = 1; Funct3E = 3'b000;
        tick;
        ProdM = {64'h0, 64'hCAFE_0000_0000_0042};
        tick;
        chk("pre_rst_validW", MulValidW, 1);
        #2 reset = 0;
        #1;
        chk("arst_validM", MulValidM, 0);
        chk("arst_resM", MulResultM, 0);
        chk("arst_validW", MulValidW, 0);
        chk("arst_resW", MulResultW, 0);
        #1 reset = 1;
        tick;
        ProdM = {64'h0, 64'h0000_0000_0000_0777};
        MulE = 0;
        chk("post_rst_validW_early", MulValidW, 0);
        tick;
        chk("post_rst_resW", MulResultW, 64'h777);
        chk("post_rst_validW", MulValidW, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
